// File: rtl/hpdcache_cmo_req_gen_if.sv
// Bus bundle for the CMO request initiator: core-side request/response,
// CMO-handler request channel and status outputs.
// The slave modport is the initiator's view; the master modport is the
// surrounding environment (request arbiter, CMO handler, response sink).
interface hpdcache_cmo_req_gen_if #(
    parameter int unsigned ADDR_WIDTH = 49,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned SID_WIDTH  = 3,
    parameter int unsigned TID_WIDTH  = 6
);
    // core request channel
    logic                  core_req_valid_i;
    logic                  core_req_ready_o;
    logic [2:0]            core_req_op_i;
    logic [ADDR_WIDTH-1:0] core_req_addr_i;
    logic [WORD_WIDTH-1:0] core_req_wdata_i;
    logic [SID_WIDTH-1:0]  core_req_sid_i;
    logic [TID_WIDTH-1:0]  core_req_tid_i;
    logic                  core_req_need_rsp_i;

    // CMO handler request channel
    logic                  cmoh_req_valid_o;
    logic                  cmoh_req_ready_i;
    logic [3:0]            cmoh_req_op_o;
    logic [ADDR_WIDTH-1:0] cmoh_req_addr_o;
    logic [WORD_WIDTH-1:0] cmoh_req_wdata_o;

    // core response channel
    logic                  core_rsp_valid_o;
    logic                  core_rsp_ready_i;
    logic [SID_WIDTH-1:0]  core_rsp_sid_o;
    logic [TID_WIDTH-1:0]  core_rsp_tid_o;
    logic                  core_rsp_error_o;

    // status
    logic                  busy_o;
    logic [31:0]           cmo_cnt_o;

    modport slave (
        input  core_req_valid_i, core_req_op_i, core_req_addr_i, core_req_wdata_i,
        input  core_req_sid_i, core_req_tid_i, core_req_need_rsp_i,
        output core_req_ready_o,
        output cmoh_req_valid_o, cmoh_req_op_o, cmoh_req_addr_o, cmoh_req_wdata_o,
        input  cmoh_req_ready_i,
        output core_rsp_valid_o, core_rsp_sid_o, core_rsp_tid_o, core_rsp_error_o,
        input  core_rsp_ready_i,
        output busy_o, cmo_cnt_o
    );

    modport master (
        output core_req_valid_i, core_req_op_i, core_req_addr_i, core_req_wdata_i,
        output core_req_sid_i, core_req_tid_i, core_req_need_rsp_i,
        input  core_req_ready_o,
        input  cmoh_req_valid_o, cmoh_req_op_o, cmoh_req_addr_o, cmoh_req_wdata_o,
        output cmoh_req_ready_i,
        input  core_rsp_valid_o, core_rsp_sid_o, core_rsp_tid_o, core_rsp_error_o,
        output core_rsp_ready_i,
        input  busy_o, cmo_cnt_o
    );
endinterface

// File: rtl/hpdcache_cmo_req_gen.sv
// CMO request initiator. Accepts one encoded cache-management request at a
// time, issues it to the CMO handler as a one-hot operation, detects
// completion from the handler's ready, optionally answers the requester and
// counts operations accepted by the handler. Illegal op codes never reach
// the handler; they are either answered with an error or silently dropped.
module hpdcache_cmo_req_gen #(
    parameter int unsigned ADDR_WIDTH = 49,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned SID_WIDTH  = 3,
    parameter int unsigned TID_WIDTH  = 6
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    hpdcache_cmo_req_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RSP       = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  error_q;
    logic                  error_d;
    logic [31:0]           cnt_q;

    // latched request fields (no reset: only observed while meaningful)
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [SID_WIDTH-1:0]  sid_q;
    logic [TID_WIDTH-1:0]  tid_q;
    logic                  need_rsp_q;

    logic                  accept;
    logic                  req_op_legal;
    logic                  issue_hs;
    logic [3:0]            op_onehot;

    // op codes 4..7 are the illegal ones, so bit 2 alone flags them
    assign req_op_legal = ~bus.core_req_op_i[2];
    assign accept       = (state_q == IDLE) && bus.core_req_valid_i;
    assign issue_hs     = (state_q == ISSUE) && bus.cmoh_req_ready_i;

    // next-state and error-flag decision
    always_comb begin
        state_d = state_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.core_req_valid_i) begin
                    if (req_op_legal) begin
                        state_d = ISSUE;
                    end else if (bus.core_req_need_rsp_i) begin
                        state_d = RSP;
                        error_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.cmoh_req_ready_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // handler ready here already reflects its post-acceptance
                // state, so ready means the operation has finished
                if (bus.cmoh_req_ready_i) begin
                    state_d = need_rsp_q ? RSP : IDLE;
                end
            end
            RSP: begin
                if (bus.core_rsp_ready_i) begin
                    state_d = IDLE;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // control state: FSM, error flag and issued-operation counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            error_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (issue_hs) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // capture request fields on acceptance
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q       <= bus.core_req_op_i;
            addr_q     <= bus.core_req_addr_i;
            wdata_q    <= bus.core_req_wdata_i;
            sid_q      <= bus.core_req_sid_i;
            tid_q      <= bus.core_req_tid_i;
            need_rsp_q <= bus.core_req_need_rsp_i;
        end
    end

    // one-hot operation decode from the latched op code
    always_comb begin
        op_onehot = 4'b0000;
        unique case (op_q)
            3'd0:    op_onehot = 4'b0001;
            3'd1:    op_onehot = 4'b0010;
            3'd2:    op_onehot = 4'b0100;
            3'd3:    op_onehot = 4'b1000;
            default: op_onehot = 4'b0000;
        endcase
    end

    assign bus.core_req_ready_o = (state_q == IDLE);
    assign bus.cmoh_req_valid_o = (state_q == ISSUE);
    assign bus.cmoh_req_op_o    = op_onehot;
    assign bus.cmoh_req_addr_o  = addr_q;
    assign bus.cmoh_req_wdata_o = wdata_q;
    assign bus.core_rsp_valid_o = (state_q == RSP);
    assign bus.core_rsp_sid_o   = sid_q;
    assign bus.core_rsp_tid_o   = tid_q;
    assign bus.core_rsp_error_o = error_q;
    assign bus.busy_o           = (state_q != IDLE);
    assign bus.cmo_cnt_o        = cnt_q;

endmodule

// File: tb/tb_hpdcache_cmo_req_gen.sv
// Bench for hpdcache_cmo_req_gen: directed scenarios plus randomized
// transactions, each checked cycle by cycle against a transaction-level
// expectation (one-hot op, latencies, echoed IDs, error, running count).
module tb_hpdcache_cmo_req_gen;

    localparam int unsigned AW = 49;
    localparam int unsigned WW = 64;
    localparam int unsigned SW = 3;
    localparam int unsigned TW = 6;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hpdcache_cmo_req_gen_if #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .SID_WIDTH(SW), .TID_WIDTH(TW)
    ) bus ();

    hpdcache_cmo_req_gen #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .SID_WIDTH(SW), .TID_WIDTH(TW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // put junk on the request fields so the latched copies are exercised
    task automatic scramble_req();
        bus.core_req_op_i       = 3'($urandom);
        bus.core_req_addr_i     = AW'({$urandom, $urandom});
        bus.core_req_wdata_i    = {$urandom, $urandom};
        bus.core_req_sid_i      = SW'($urandom);
        bus.core_req_tid_i      = TW'($urandom);
        bus.core_req_need_rsp_i = 1'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_req_ready"}, 64'(bus.core_req_ready_o), 64'd1);
        check_val({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        check_val({tag, "_cmoh_valid"}, 64'(bus.cmoh_req_valid_o), 64'd0);
        check_val({tag, "_rsp_valid"}, 64'(bus.core_rsp_valid_o), 64'd0);
        check_val({tag, "_cnt"}, 64'(bus.cmo_cnt_o), 64'(exp_cnt));
    endtask

    // One request from presentation to return to IDLE.
    // pre  : cycles the handler is busy before accepting the issue
    // done : cycles the handler stays not-ready after acceptance
    // bp   : cycles of response backpressure
    task automatic run_txn(input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [WW-1:0] wdata, input logic [SW-1:0] sid,
                           input logic [TW-1:0] tid, input logic need_rsp,
                           input int pre, input int done, input int bp);
        logic       legal;
        logic [3:0] onehot;
        legal  = (op < 3'd4);
        onehot = legal ? (4'b0001 << op) : 4'b0000;

        check_val("pre_req_ready", 64'(bus.core_req_ready_o), 64'd1);
        bus.core_req_valid_i    = 1'b1;
        bus.core_req_op_i       = op;
        bus.core_req_addr_i     = addr;
        bus.core_req_wdata_i    = wdata;
        bus.core_req_sid_i      = sid;
        bus.core_req_tid_i      = tid;
        bus.core_req_need_rsp_i = need_rsp;
        bus.cmoh_req_ready_i    = (pre == 0);
        @(posedge clk);
        @(negedge clk);
        bus.core_req_valid_i = 1'b0;
        scramble_req();

        if (legal) begin
            for (int i = 0; i <= pre; i++) begin
                check_val("issue_valid", 64'(bus.cmoh_req_valid_o), 64'd1);
                check_val("issue_op", 64'(bus.cmoh_req_op_o), 64'(onehot));
                check_val("issue_addr", 64'(bus.cmoh_req_addr_o), 64'(addr));
                check_val("issue_wdata", 64'(bus.cmoh_req_wdata_o), 64'(wdata));
                check_val("issue_req_ready", 64'(bus.core_req_ready_o), 64'd0);
                check_val("issue_busy", 64'(bus.busy_o), 64'd1);
                check_val("issue_rsp_valid", 64'(bus.core_rsp_valid_o), 64'd0);
                check_val("issue_cnt", 64'(bus.cmo_cnt_o), 64'(exp_cnt));
                bus.cmoh_req_ready_i = (i == pre);
                @(posedge clk);
                @(negedge clk);
            end
            exp_cnt = exp_cnt + 32'd1;
            for (int j = 0; j <= done; j++) begin
                check_val("wait_cmoh_valid", 64'(bus.cmoh_req_valid_o), 64'd0);
                check_val("wait_req_ready", 64'(bus.core_req_ready_o), 64'd0);
                check_val("wait_busy", 64'(bus.busy_o), 64'd1);
                check_val("wait_rsp_valid", 64'(bus.core_rsp_valid_o), 64'd0);
                check_val("wait_cnt", 64'(bus.cmo_cnt_o), 64'(exp_cnt));
                bus.cmoh_req_ready_i = (j == done);
                @(posedge clk);
                @(negedge clk);
            end
        end

        if (need_rsp) begin
            for (int k = 0; k <= bp; k++) begin
                check_val("rsp_valid", 64'(bus.core_rsp_valid_o), 64'd1);
                check_val("rsp_sid", 64'(bus.core_rsp_sid_o), 64'(sid));
                check_val("rsp_tid", 64'(bus.core_rsp_tid_o), 64'(tid));
                check_val("rsp_error", 64'(bus.core_rsp_error_o), 64'(!legal));
                check_val("rsp_req_ready", 64'(bus.core_req_ready_o), 64'd0);
                check_val("rsp_cmoh_valid", 64'(bus.cmoh_req_valid_o), 64'd0);
                check_val("rsp_cnt", 64'(bus.cmo_cnt_o), 64'(exp_cnt));
                bus.core_rsp_ready_i = (k == bp);
                @(posedge clk);
                @(negedge clk);
            end
            bus.core_rsp_ready_i = 1'b0;
        end
        bus.cmoh_req_ready_i = 1'b1;
        check_idle("end");
    endtask

    initial begin
        exp_cnt                  = 32'd0;
        rst_n                    = 1'b0;
        bus.core_req_valid_i     = 1'b0;
        bus.cmoh_req_ready_i     = 1'b1;
        bus.core_rsp_ready_i     = 1'b0;
        scramble_req();

        repeat (2) @(negedge clk);
        check_idle("reset");
        check_val("reset_error", 64'(bus.core_rsp_error_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // fence, handler always ready, response requested
        run_txn(3'd0, AW'(49'h1_2345_6789_ABCD), 64'h0, 3'd2, 6'd5, 1'b1, 0, 0, 0);
        check_val("fence_cnt", 64'(bus.cmo_cnt_o), 64'd1);
        // inval_by_set, handler busy 10 cycles after acceptance
        run_txn(3'd2, AW'(49'h40), 64'hA, 3'd1, 6'd9, 1'b1, 0, 10, 0);
        // handler busy for 4 cycles when the request arrives
        run_txn(3'd1, AW'(49'h0_DEAD_BEEF_0000), 64'h5, 3'd3, 6'd17, 1'b0, 4, 0, 0);
        // illegal op with response
        run_txn(3'd6, AW'(49'h77), 64'h0, 3'd4, 6'd33, 1'b1, 0, 0, 0);
        // illegal op without response: dropped
        run_txn(3'd7, AW'(49'h78), 64'h0, 3'd5, 6'd34, 1'b0, 0, 0, 0);
        // response backpressure
        run_txn(3'd3, AW'(49'h0), 64'h0, 3'd7, 6'd63, 1'b1, 0, 0, 3);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        check_val("wrap_preload", 64'(bus.cmo_cnt_o), 64'(exp_cnt));
        run_txn(3'd3, AW'(49'h100), 64'h0, 3'd0, 6'd1, 1'b1, 0, 0, 0);
        check_val("wrap_cnt", 64'(bus.cmo_cnt_o), 64'd0);

        // randomized transactions
        for (int n = 0; n < 200; n++) begin
            run_txn(3'($urandom_range(0, 7)), AW'({$urandom, $urandom}),
                    {$urandom, $urandom}, SW'($urandom), TW'($urandom),
                    1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        // reset while a request is being issued
        check_val("pre_abort_cnt_nonzero", 64'(bus.cmo_cnt_o != 32'd0), 64'd1);
        bus.core_req_valid_i    = 1'b1;
        bus.core_req_op_i       = 3'd1;
        bus.core_req_need_rsp_i = 1'b1;
        bus.cmoh_req_ready_i    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.core_req_valid_i = 1'b0;
        check_val("abort_issue_valid", 64'(bus.cmoh_req_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check_idle("abort_reset");
        @(negedge clk);
        rst_n                = 1'b1;
        bus.cmoh_req_ready_i = 1'b1;
        @(negedge clk);
        check_idle("abort_release");
        run_txn(3'd0, AW'(49'h5), 64'h0, 3'd6, 6'd12, 1'b1, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
